// File: rtl/alu_rv32.sv
// RV32 integer ALU: combinational result and flags, plus a registered copy of the result.
// Combinational outputs are forced to a quiet state while the reset is asserted.
module alu_rv32 (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [4:0]  op,
    output logic [31:0] res,
    output logic        zero,
    output logic        neg,
    output logic        carry,
    output logic        ovf,
    output logic [31:0] res_q
);

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SLL  = 5'd3;
    localparam logic [4:0] OP_SLT  = 5'd4;
    localparam logic [4:0] OP_SLTU = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_SRL  = 5'd7;
    localparam logic [4:0] OP_SRA  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;

    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [4:0]  w_shamt;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic        w_slt;
    logic [31:0] w_res;
    logic        w_carry;
    logic        w_ovf;
    logic [31:0] r_res_q;

    assign w_sum     = {1'b0, lhs} + {1'b0, rhs};
    // Bit 32 of the 33-bit difference is the borrow, so carry is its inverse.
    assign w_diff    = {1'b0, lhs} - {1'b0, rhs};
    assign w_shamt   = rhs[4:0];
    assign w_add_ovf = (lhs[31] == rhs[31]) && (w_sum[31] != lhs[31]);
    assign w_sub_ovf = (lhs[31] != rhs[31]) && (w_diff[31] != lhs[31]);
    assign w_slt     = $signed(lhs) < $signed(rhs);

    // Operation decode; reset and reserved codes yield a zero result with clear flags.
    always_comb begin
        w_res   = 32'd0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        if (!RST_X) begin
            w_res   = 32'd0;
            w_carry = 1'b0;
            w_ovf   = 1'b0;
        end else begin
            case (op)
                OP_NOP:  w_res = 32'd0;
                OP_ADD: begin
                    w_res   = w_sum[31:0];
                    w_carry = w_sum[32];
                    w_ovf   = w_add_ovf;
                end
                OP_SUB: begin
                    w_res   = w_diff[31:0];
                    w_carry = ~w_diff[32];
                    w_ovf   = w_sub_ovf;
                end
                OP_SLL:  w_res = lhs << w_shamt;
                OP_SLT:  w_res = {31'd0, w_slt};
                OP_SLTU: w_res = {31'd0, (lhs < rhs)};
                OP_XOR:  w_res = lhs ^ rhs;
                OP_SRL:  w_res = lhs >> w_shamt;
                OP_SRA:  w_res = $unsigned($signed(lhs) >>> w_shamt);
                OP_OR:   w_res = lhs | rhs;
                OP_AND:  w_res = lhs & rhs;
                default: w_res = 32'd0;
            endcase
        end
    end

    // Result register; no enable, cleared asynchronously by reset.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_res_q <= 32'd0;
        end else begin
            r_res_q <= w_res;
        end
    end

    assign res   = w_res;
    assign zero  = (w_res == 32'd0);
    assign neg   = w_res[31];
    assign carry = w_carry;
    assign ovf   = w_ovf;
    assign res_q = r_res_q;

endmodule

// File: tb/tb_alu_rv32.sv
// Scoreboard bench for alu_rv32: a behavioural model queues expected results at drive time,
// which are popped and compared against the combinational outputs and then against res_q.
module tb_alu_rv32;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        neg;
        logic        carry;
        logic        ovf;
    } exp_t;

    logic        CLK;
    logic        RST_X;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
    logic [31:0] res_q;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        sb_q[$];
    logic [31:0] resq_q[$];

    alu_rv32 u_dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .lhs   (lhs),
        .rhs   (rhs),
        .op    (op),
        .res   (res),
        .zero  (zero),
        .neg   (neg),
        .carry (carry),
        .ovf   (ovf),
        .res_q (res_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        longint      sa;
        longint      sb;
        longint      t;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = 32'd0;
        e.carry = 1'b0;
        e.ovf = 1'b0;
        case (o)
            5'd1: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[31:0];
                e.carry = s[32];
                t = sa + sb;
                e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            5'd2: begin
                e.res = a - b;
                e.carry = (a >= b);
                t = sa - sb;
                e.ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            5'd3:  e.res = a << b[4:0];
            5'd4:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            5'd5:  e.res = (a < b) ? 32'd1 : 32'd0;
            5'd6:  e.res = a ^ b;
            5'd7:  e.res = a >> b[4:0];
            5'd8: begin
                r = a;
                for (int k = 0; k < int'(b[4:0]); k++) r = {r[31], r[31:1]};
                e.res = r;
            end
            5'd9:  e.res = a | b;
            5'd10: e.res = a & b;
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        e.neg = e.res[31];
        return e;
    endfunction

    // Drive one operation, check combinational outputs, then res_q after the next edge.
    task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit use_exp, input logic [31:0] exp_res);
        exp_t        e;
        logic [31:0] rq;
        sb_q.push_back(model(o, a, b));
        op = o;
        lhs = a;
        rhs = b;
        #1;
        e = sb_q.pop_front();
        check_eq("res", res, e.res);
        check_eq("zero", {31'd0, zero}, {31'd0, e.zero});
        check_eq("neg", {31'd0, neg}, {31'd0, e.neg});
        check_eq("carry", {31'd0, carry}, {31'd0, e.carry});
        check_eq("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        if (use_exp) check_eq("res_directed", res, exp_res);
        resq_q.push_back(e.res);
        @(posedge CLK);
        #1;
        rq = resq_q.pop_front();
        check_eq("res_q", res_q, rq);
    endtask

    initial begin
        RST_X = 1'b0;
        op = 5'd1;
        lhs = 32'h0000_1111;
        rhs = 32'h0000_2222;
        #3;
        check_eq("rst_res", res, 32'd0);
        check_eq("rst_zero", {31'd0, zero}, 32'd1);
        check_eq("rst_carry", {31'd0, carry}, 32'd0);
        check_eq("rst_res_q", res_q, 32'd0);
        @(posedge CLK);
        #1;
        check_eq("rst_res_q_clk", res_q, 32'd0);
        @(negedge CLK);
        RST_X = 1'b1;
        #1;
        check_eq("release_res", res, 32'h0000_3333);
        check_eq("release_res_q", res_q, 32'd0);
        @(posedge CLK);
        #1;
        check_eq("first_capture", res_q, 32'h0000_3333);

        // Directed corner cases
        drive(5'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000);
        check_eq("add_wrap_carry", {31'd0, carry}, 32'd1);
        drive(5'd1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000);
        check_eq("add_ovf", {31'd0, ovf}, 32'd1);
        drive(5'd2, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE);
        check_eq("sub_borrow", {31'd0, carry}, 32'd0);
        drive(5'd2, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF);
        check_eq("sub_ovf", {31'd0, ovf}, 32'd1);
        drive(5'd8, 32'h8000_0000, 32'h0000_0024, 1'b1, 32'hF800_0000);
        drive(5'd7, 32'h8000_0000, 32'h0000_0024, 1'b1, 32'h0800_0000);
        drive(5'd3, 32'h0000_0001, 32'h0000_001F, 1'b1, 32'h8000_0000);
        drive(5'd4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001);
        drive(5'd5, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000);
        drive(5'd4, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000);
        drive(5'd5, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000);
        drive(5'd0, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 32'h0000_0000);
        drive(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
        drive(5'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'h0FF0_0FF0);
        drive(5'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hFFF0_FFF0);
        drive(5'd10, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000);

        // Random operations, including reserved codes
        for (int i = 0; i < 60; i++) begin
            drive(5'($urandom_range(0, 31)), $urandom, $urandom, 1'b0, 32'd0);
        end

        // Mid-run asynchronous reset
        drive(5'd1, 32'h0000_1234, 32'h0000_0000, 1'b1, 32'h0000_1234);
        check_eq("pre_reset_res_q", res_q, 32'h0000_1234);
        #1;
        RST_X = 1'b0;
        #1;
        check_eq("async_res_q", res_q, 32'd0);
        check_eq("async_res", res, 32'd0);
        check_eq("async_zero", {31'd0, zero}, 32'd1);
        RST_X = 1'b1;
        #1;
        check_eq("rel_res", res, 32'h0000_1234);
        check_eq("rel_res_q_hold", res_q, 32'd0);
        @(posedge CLK);
        #1;
        check_eq("rel_res_q_capture", res_q, 32'h0000_1234);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rv32.md
ALU_RV32 -- requirements
Module: alu_rv32

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named CLK and RST_X.
REQ-002 CLK  input  1  clock; rising edge samples the result register.
REQ-003 RST_X  input  1  async active-low reset.
REQ-004 lhs  input  32  left operand (rs1 or pc).
REQ-005 rhs  input  32  right operand (rs2 or immediate); shift amount is rhs[4:0].
REQ-006 op  input  5  operation code.
REQ-007 res  output  32  combinational result.
REQ-008 zero  output  1  res == 0.
REQ-009 neg  output  1  res[31].
REQ-010 carry  output  1  carry-out of ADD, or NOT borrow of SUB; 0 for other ops.
REQ-011 ovf  output  1  signed overflow of ADD/SUB; 0 for other ops.
REQ-012 res_q  output  32  res registered on CLK.

Function
REQ-013 op encoding: 0 NOP, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND; codes 11-31 are reserved.
REQ-014 res SHALL be combinational from lhs/rhs/op with zero cycle latency, so a caller can use it in the same cycle as the operands.
REQ-015 NOP and reserved codes SHALL give res = 0 and carry = ovf = 0.
REQ-016 ADD: res = (lhs + rhs) mod 2^32; carry = bit 32 of the 33-bit sum; ovf = operands have the same sign and res sign differs.
REQ-017 SUB: res = (lhs - rhs) mod 2^32; carry = 1 iff lhs >= rhs unsigned; ovf = operand signs differ and res sign differs from lhs.
REQ-018 SLL: res = lhs << rhs[4:0]; rhs[31:5] ignored.
REQ-019 SRL: logical right shift by rhs[4:0], zero fill.
REQ-020 SRA: arithmetic right shift by rhs[4:0], fill with lhs[31].
REQ-021 SLT: res = 1 if signed lhs < signed rhs, else 0; upper 31 bits are 0.
REQ-022 SLTU: res = 1 if unsigned lhs < unsigned rhs, else 0; upper 31 bits are 0.
REQ-023 XOR, OR, AND: bitwise over all 32 bits.
REQ-024 zero and neg SHALL be derived from the final res of every op, including NOP.
REQ-025 res_q SHALL load res on each rising CLK while RST_X = 1; there is no enable.
REQ-026 The design SHALL contain no other state; outputs SHALL be glitch-free only after operands settle, and there SHALL be no combinational loop from res back to the inputs.

Reset
REQ-027 While RST_X = 0: res = 0, zero = 1, neg = 0, carry = 0, ovf = 0, regardless of the inputs.
REQ-028 While RST_X = 0, res_q SHALL clear to 0 immediately and asynchronously, independent of CLK.
REQ-029 On RST_X deassertion, res SHALL reflect the inputs combinationally.
REQ-030 res_q SHALL first capture a result on the first rising CLK after RST_X deassertion.

Verification
REQ-031 ADD lhs=0xFFFFFFFF, rhs=1 -> res=0, zero=1, carry=1, ovf=0; ADD 0x7FFFFFFF+1 -> res=0x80000000, ovf=1, neg=1.
REQ-032 SUB lhs=5, rhs=7 -> res=0xFFFFFFFE, carry=0; SUB 0x80000000-1 -> res=0x7FFFFFFF, ovf=1.
REQ-033 SRA lhs=0x80000000, rhs=0x24 (amount 4) -> res=0xF8000000; SRL same -> 0x08000000; SLL lhs=1, rhs=31 -> 0x80000000.
REQ-034 SLT lhs=0xFFFFFFFF, rhs=1 -> res=1; SLTU same operands -> res=0; equal operands -> 0 for both.
REQ-035 op=0 and op=31 with any operands -> res=0, zero=1; XOR/OR/AND of 0xF0F0F0F0 with 0xFF00FF00 -> 0x0FF00FF0 / 0xFFF0FFF0 / 0xF000F000.
REQ-036 Assert RST_X=0 mid-run with res_q=0x1234 -> res_q=0 and res=0 without a clock edge; release -> res_q updates on the next rising CLK.
